apb_multi_slave_monitor: RTL and testbench

//  Synthesizable APB3/APB4 protocol monitor for a bus with NUM_SEL slave selects. Sits passively on the

---
 rtl/apb_multi_slave_monitor_if.sv | 34 +++
 rtl/apb_multi_slave_monitor.sv | 196 +++++++++++++++++++
 tb/tb_apb_multi_slave_monitor.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_multi_slave_monitor_if.sv
// ---------------------------------------------------------------------------
// apb_multi_slave_monitor_if
// APB3/APB4 bridge-side bus bundle shared by a master, its slaves and any
// passive observers.
//   paddr    address                  psel     one select line per slave
//   penable  access phase             pwrite   1 = write
//   pwdata   write data               pstrb    write byte strobes
//   pready   slave ready              pslverr  slave error
// Modports: master (drives the request), slave (drives the response),
// monitor (observes everything and drives nothing).
// ---------------------------------------------------------------------------
interface apb_multi_slave_monitor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 4
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [NUM_SEL-1:0]    psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic                  pready;
  logic                  pslverr;

  modport master  (output paddr, psel, penable, pwrite, pwdata, pstrb,
                   input  pready, pslverr);
  modport slave   (input  paddr, psel, penable, pwrite, pwdata, pstrb,
                   output pready, pslverr);
  modport monitor (input  paddr, psel, penable, pwrite, pwdata, pstrb,
                          pready, pslverr);
endinterface

// File: rtl/apb_multi_slave_monitor.sv
// ---------------------------------------------------------------------------
// apb_multi_slave_monitor
// Passive APB3/APB4 protocol checker for a bus with NUM_SEL slave selects.
// Tracks the IDLE/SETUP/ACCESS transfer FSM, reports protocol violations as
// registered per-cycle pulses plus sticky bits, and keeps saturating
// transfer / error / wait-state statistics.
// Ports:
//   pclk, preset   clock, asynchronous active-high reset
//   apb            observed bus (monitor modport)
//   clr            synchronous clear of sticky bits, first_sel and counters
//   viol           per-cycle violation pulses (one cycle after the event)
//   viol_sticky    OR of viol since reset / clr
//   first_sel      psel index at first violation, all-ones = none / idle
//   wr_count, rd_count, err_count   completed writes, reads, slave errors
//   wait_max       largest wait-state count of any completed transfer
//   bus_state      tracked FSM: 00 IDLE, 01 SETUP, 10 ACCESS
// ---------------------------------------------------------------------------
module apb_multi_slave_monitor #(
  parameter int  ADDR_WIDTH  = 32,
  parameter int  DATA_WIDTH  = 32,
  parameter int  NUM_SEL     = 4,
  parameter int  TIMEOUT     = 100,
  parameter int  CNT_WIDTH   = 16,
  parameter int  CHECK_ALIGN = 1,
  localparam int STRB_W      = DATA_WIDTH / 8,
  localparam int SEL_W       = $clog2(NUM_SEL) + 1
) (
  input  logic                       pclk,
  input  logic                       preset,
  apb_multi_slave_monitor_if.monitor apb,
  input  logic                       clr,
  output logic [7:0]                 viol,
  output logic [7:0]                 viol_sticky,
  output logic [SEL_W-1:0]           first_sel,
  output logic [CNT_WIDTH-1:0]       wr_count,
  output logic [CNT_WIDTH-1:0]       rd_count,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic [CNT_WIDTH-1:0]       wait_max,
  output logic [1:0]                 bus_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;
  localparam logic [NUM_SEL-1:0]    SEL_ONE    = NUM_SEL'(1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

  // The FSM register follows the transfer one cycle behind the bus: it is
  // IDLE during a setup cycle, SETUP during the first access cycle and
  // ACCESS during every later access (wait) cycle. 'cur' is the phase of
  // the cycle currently on the bus.
  state_t st, st_n, cur;

  logic sel_any, completion;
  logic [7:0] viol_c;

  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_W-1:0]     cap_strb;
  logic [NUM_SEL-1:0]    cap_sel;
  logic [SEL_W-1:0]      cap_idx;
  logic [CNT_WIDTH-1:0]  wait_cnt;

  logic [7:0]           sticky_n;
  logic [SEL_W-1:0]     first_sel_n;
  logic [CNT_WIDTH-1:0] wr_n, rd_n, err_n, wmax_n;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign sel_any   = |apb.psel;
  assign bus_state = st;

  // State register
  always_ff @(posedge pclk or posedge preset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (preset) st <= ST_IDLE;
    else        st <= st_n;
  end

  // Phase of the current bus cycle
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    cur = st;
    if (st == ST_IDLE && sel_any && !apb.penable) cur = ST_SETUP;
    else if (st == ST_SETUP)                       cur = ST_ACCESS;
  end

  // Violation detection and completion
  always_comb begin
    viol_c     = '0;
    completion = (cur == ST_ACCESS) && sel_any && apb.penable && apb.pready;

    viol_c[0] = (apb.psel & (apb.psel - SEL_ONE)) != '0;
    viol_c[1] = (st == ST_IDLE) && apb.penable;
    viol_c[2] = (st == ST_SETUP) && !(apb.penable && apb.psel == cap_sel);
    viol_c[3] = (cur == ST_ACCESS) &&
                (apb.paddr != cap_addr || apb.pwrite != cap_write ||
                 apb.psel != cap_sel ||
                 (apb.pwrite && (apb.pwdata != cap_wdata || apb.pstrb != cap_strb)));
    // st == ACCESS means the previous cycle was a wait state
    viol_c[4] = (st == ST_ACCESS) && (!sel_any || !apb.penable);
    // Fires on the wait cycle that brings the counter to TIMEOUT, once only
    viol_c[5] = (cur == ST_ACCESS) && !apb.pready && wait_cnt != CNT_MAX &&
                (32'(wait_cnt) + 1 == TIMEOUT);
    viol_c[6] = apb.pslverr && !completion;
    viol_c[7] = (cur == ST_SETUP) &&
                ((CHECK_ALIGN != 0 && (apb.paddr & ALIGN_MASK) != '0) ||
                 (!apb.pwrite && apb.pstrb != '0));
  end

  // Next state: a broken handshake resynchronises on the current cycle,
  // treating it as a fresh setup if it looks like one.
  always_comb begin
    st_n = cur;
    if (viol_c[2] || viol_c[4])
      st_n = (sel_any && !apb.penable) ? ST_SETUP : ST_IDLE;
    else if (cur == ST_ACCESS && apb.pready)
      st_n = ST_IDLE;
  end

  // Index of the captured select line (all-ones when none captured)
  always_comb begin
    cap_idx = '1;
    for (int i = 0; i < NUM_SEL; i++)
      if (cap_sel[i]) cap_idx = SEL_W'(i);
  end

  // Next values of status and statistics: clr applies first, then this
  // cycle's events, so a violation or completion coinciding with clr is kept.
  always_comb begin
    sticky_n    = (clr ? 8'h00 : viol_sticky) | viol_c;
    first_sel_n = clr ? '1 : first_sel;
    if ((clr || viol_sticky == 8'h00) && viol_c != 8'h00)
      first_sel_n = (st == ST_IDLE) ? '1 : cap_idx;

    wr_n   = clr ? '0 : wr_count;
    rd_n   = clr ? '0 : rd_count;
    err_n  = clr ? '0 : err_count;
    wmax_n = clr ? '0 : wait_max;
    if (completion) begin
      if (apb.pwrite) wr_n = sat_inc(wr_n);
      else            rd_n = sat_inc(rd_n);
      if (apb.pslverr) err_n = sat_inc(err_n);
      if (wait_cnt > wmax_n) wmax_n = wait_cnt;
    end
  end

  // Capture, wait counter and registered outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      // NOTE: the capture registers are reset too, so the first access
      // compare after reset never sees X values.
      cap_addr    <= '0;
      cap_write   <= 1'b0;
      cap_wdata   <= '0;
      cap_strb    <= '0;
      cap_sel     <= '0;
      wait_cnt    <= '0;
      viol        <= '0;
      viol_sticky <= '0;
      first_sel   <= '1;
      wr_count    <= '0;
      rd_count    <= '0;
      err_count   <= '0;
      wait_max    <= '0;
    end else begin
      if (st_n == ST_SETUP) begin
        cap_addr  <= apb.paddr;
        cap_write <= apb.pwrite;
        cap_wdata <= apb.pwdata;
        cap_strb  <= apb.pstrb;
        cap_sel   <= apb.psel;
        wait_cnt  <= '0;
      end else if (cur == ST_ACCESS && !apb.pready) begin
        wait_cnt <= sat_inc(wait_cnt);
      end
      viol        <= viol_c;
      viol_sticky <= sticky_n;
      first_sel   <= first_sel_n;
      wr_count    <= wr_n;
      rd_count    <= rd_n;
      err_count   <= err_n;
      wait_max    <= wmax_n;
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_monitor.sv
// ---------------------------------------------------------------------------
// tb_apb_multi_slave_monitor
// Directed bench for apb_multi_slave_monitor (NUM_SEL=4, TIMEOUT=8,
// CNT_WIDTH=4). Inputs change 1 ns after a rising edge; registered outputs
// are sampled at that point, so they show the cycle just driven.
// ---------------------------------------------------------------------------
module tb_apb_multi_slave_monitor;

  logic pclk;
  logic preset;
  logic clr;
  logic [7:0] viol, viol_sticky;
  logic [2:0] first_sel;
  logic [3:0] wr_count, rd_count, err_count, wait_max;
  logic [1:0] bus_state;

  int n_checks = 0;
  int n_fail   = 0;

  apb_multi_slave_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(4)) bus ();

  apb_multi_slave_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(4),
    .TIMEOUT(8), .CNT_WIDTH(4), .CHECK_ALIGN(1)
  ) dut (
    .pclk(pclk), .preset(preset), .apb(bus), .clr(clr),
    .viol(viol), .viol_sticky(viol_sticky), .first_sel(first_sel),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count),
    .wait_max(wait_max), .bus_state(bus_state)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic rdy, input logic err);
    bus.psel    = sel;
    bus.penable = en;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    bus.pstrb   = strb;
    bus.pready  = rdy;
    bus.pslverr = err;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    drive(4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    clr    = 1'b0;
    preset = 1'b1;
    bus.psel = '0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
    bus.pwdata = '0; bus.pstrb = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_viol",      32'(viol),        'h00);
    check("rst_sticky",    32'(viol_sticky), 'h00);
    check("rst_first_sel", 32'(first_sel),   'h7);
    check("rst_wr_count",  32'(wr_count),    0);
    check("rst_wait_max",  32'(wait_max),    0);
    check("rst_bus_state", 32'(bus_state),   0);
    preset = 1'b0;
    idle();

    // Clean zero-wait write to slave 0
    drive(4'h1, 1'b0, 1'b1, 32'h10, 32'hA5A5_0000, 4'hF, 1'b0, 1'b0);
    drive(4'h1, 1'b1, 1'b1, 32'h10, 32'hA5A5_0000, 4'hF, 1'b1, 1'b0);
    idle();
    check("wr1_wr_count",  32'(wr_count),    1);
    check("wr1_sticky",    32'(viol_sticky), 'h00);
    check("wr1_wait_max",  32'(wait_max),    0);
    check("wr1_bus_state", 32'(bus_state),   0);

    // Read from slave 2 with three wait states
    drive(4'h4, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h4, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
    check("rd_wait_bus_state", 32'(bus_state), 2);
    drive(4'h4, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h4, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h4, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
    check("rd1_rd_count", 32'(rd_count),    1);
    check("rd1_wait_max", 32'(wait_max),    3);
    check("rd1_sticky",   32'(viol_sticky), 'h00);
    idle();

    // Address changes during the second wait cycle of a write
    drive(4'h1, 1'b0, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 1'b0, 1'b0);
    drive(4'h1, 1'b1, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 1'b0, 1'b0);
    check("addr_chg_wait1_viol", 32'(viol), 'h00);
    drive(4'h1, 1'b1, 1'b1, 32'h14, 32'h1111_2222, 4'hF, 1'b0, 1'b0);
    check("addr_chg_viol",      32'(viol),      'h08);
    check("addr_chg_first_sel", 32'(first_sel), 0);
    drive(4'h1, 1'b1, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 1'b0, 1'b0);
    check("addr_chg_pulse_end", 32'(viol), 'h00);
    drive(4'h1, 1'b1, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 1'b1, 1'b0);
    check("addr_chg_wr_count", 32'(wr_count), 2);
    idle();

    // Two selects at once, then the aborted transfer it started
    drive(4'h3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    check("multi_sel_viol", 32'(viol), 'h01);
    idle();
    check("multi_sel_abort_viol", 32'(viol), 'h0C);
    idle();

    // Slave error during SETUP, then a read completing with pslverr
    drive(4'h2, 1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b1);
    check("slverr_setup_viol", 32'(viol), 'h40);
    drive(4'h2, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 1'b0);
    drive(4'h8, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h8, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b1);
    check("slverr_cpl_viol", 32'(viol),      'h00);
    check("err_count",       32'(err_count), 1);
    check("rd_count_3",      32'(rd_count),  3);
    idle();
    check("sticky_before_clr",    32'(viol_sticky), 'h4D);
    check("first_sel_before_clr", 32'(first_sel),   0);

    // Clear
    clr = 1'b1;
    idle();
    clr = 1'b0;
    check("clr_sticky",    32'(viol_sticky), 'h00);
    check("clr_first_sel", 32'(first_sel),   'h7);
    check("clr_wr_count",  32'(wr_count),    0);
    check("clr_err_count", 32'(err_count),   0);
    check("clr_wait_max",  32'(wait_max),    0);

    // Clear coinciding with a new violation: the violation survives
    clr = 1'b1;
    drive(4'h3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    clr = 1'b0;
    check("clr_vs_viol_sticky",    32'(viol_sticky), 'h01);
    check("clr_vs_viol_first_sel", 32'(first_sel),   'h7);
    idle();
    check("clr_vs_viol_sticky2", 32'(viol_sticky), 'h0D);
    clr = 1'b1;
    idle();
    clr = 1'b0;

    // Misaligned write address in SETUP
    drive(4'h1, 1'b0, 1'b1, 32'h12, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    check("misalign_viol",      32'(viol),      'h80);
    check("misalign_first_sel", 32'(first_sel), 'h7);
    drive(4'h1, 1'b1, 1'b1, 32'h12, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    check("misalign_cpl_viol", 32'(viol),     'h00);
    check("misalign_wr_count", 32'(wr_count), 1);
    idle();

    // Timeout: 20 wait cycles, single pulse after the eighth
    drive(4'h4, 1'b0, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      drive(4'h4, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, 1'b0);
      check($sformatf("timeout_wait%0d_viol", k), 32'(viol), (k == 8) ? 'h20 : 'h00);
    end
    check("timeout_bus_state", 32'(bus_state), 2);
    drive(4'h4, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b1, 1'b0);
    check("timeout_rd_count", 32'(rd_count),    1);
    check("timeout_wait_max", 32'(wait_max),    15);
    check("timeout_sticky",   32'(viol_sticky), 'hA0);
    idle();

    // Write counter saturation
    clr = 1'b1;
    idle();
    clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(4'h2, 1'b0, 1'b1, 32'h60, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
      drive(4'h2, 1'b1, 1'b1, 32'h60, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
      if (i == 13) check("sat_wr_count_14", 32'(wr_count), 14);
    end
    check("sat_wr_count_17", 32'(wr_count),    15);
    check("sat_sticky",      32'(viol_sticky), 'h00);
    idle();

    // Asynchronous reset in the middle of an ACCESS phase
    drive(4'h1, 1'b0, 1'b0, 32'h70, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h1, 1'b1, 1'b0, 32'h70, 32'h0, 4'h0, 1'b0, 1'b0);
    preset = 1'b1;
    #1;
    check("midrst_wr_count",  32'(wr_count),  0);
    check("midrst_rd_count",  32'(rd_count),  0);
    check("midrst_first_sel", 32'(first_sel), 'h7);
    check("midrst_bus_state", 32'(bus_state), 0);
    bus.psel = '0; bus.penable = 1'b0;
    #3;
    preset = 1'b0;
    idle();
    check("post_rst_viol",   32'(viol),        'h00);
    check("post_rst_sticky", 32'(viol_sticky), 'h00);
    drive(4'h1, 1'b0, 1'b1, 32'h10, 32'hA5A5_0000, 4'hF, 1'b0, 1'b0);
    drive(4'h1, 1'b1, 1'b1, 32'h10, 32'hA5A5_0000, 4'hF, 1'b1, 1'b0);
    check("post_rst_wr_count", 32'(wr_count), 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
